rom_access_arbiter: RTL and testbench

//  Round-robin arbiter sharing one synchronous 256x32 lookup ROM between NUM_REQ requesters.

---
 rtl/rom_access_arbiter.sv | 144 ++++++++++++++
 tb/tb_rom_access_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one synchronous lookup ROM between NUM_REQ requesters,
// with bounded bursts per requester and id-tagged read data returned two cycles after the request.
module rom_access_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      rom_en_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  output logic                      rvalid_o,
  output logic [ID_W-1:0]           rid_o,
  output logic [DATA_W-1:0]         rdata_o
);

  localparam int              CNT_W     = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_MAX);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]    NUM_REQ_X = (ID_W + 1)'(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt_p0_q, gnt_p0_d;
  logic               vld_p0_q, vld_p0_d;
  logic [ADDR_W-1:0]  addr_p0_q, addr_p0_d;
  logic [ID_W-1:0]    id_p0_q, id_p0_d;

  logic               vld_p1_q, vld_p1_d;
  logic [ID_W-1:0]    id_p1_q, id_p1_d;
  logic [DATA_W-1:0]  data_p1_q, data_p1_d;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [ID_W:0]      idx_ext;
  logic               rr_found;
  logic [ID_W-1:0]    rr_idx;
  logic               grant_ok;
  logic               burst_hold;
  logic [ID_W-1:0]    win;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_arr[k] = addr_i[k*ADDR_W +: ADDR_W];
    end
  end

  // Cyclic search starting just after the last-granted requester.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_q;
    idx_ext  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_ext = {1'b0, last_q} + (ID_W + 1)'(i);
      if (idx_ext >= NUM_REQ_X) begin
        idx_ext = idx_ext - NUM_REQ_X;
      end
      if (!rr_found && req_i[idx_ext]) begin
        rr_found = 1'b1;
        rr_idx   = idx_ext[ID_W-1:0];
      end
    end
  end

  // Burst continuation only applies while grants are back-to-back.
  always_comb begin
    grant_ok   = en_i && (|req_i);
    burst_hold = (state_q == GRANT) && req_i[last_q] && (cnt_q < CNT_MAX);
    win        = burst_hold ? last_q : rr_idx;

    state_d = grant_ok ? GRANT : IDLE;
    last_d  = grant_ok ? win : last_q;
    cnt_d   = '0;
    if (grant_ok) begin
      if ((state_q == GRANT) && (win == last_q)) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_W'(1);
      end
    end
  end

  // Stage p0: grant issue / ROM address
  always_comb begin
    vld_p0_d  = grant_ok;
    gnt_p0_d  = grant_ok ? (NUM_REQ'(1) << win) : '0;
    addr_p0_d = grant_ok ? addr_arr[win] : addr_p0_q;
    id_p0_d   = grant_ok ? win : id_p0_q;
  end

  // Stage p1: ROM data return
  always_comb begin
    vld_p1_d  = vld_p0_q;
    id_p1_d   = vld_p0_q ? id_p0_q : id_p1_q;
    data_p1_d = vld_p0_q ? rom_data_i : data_p1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      gnt_p0_q  <= '0;
      vld_p0_q  <= 1'b0;
      addr_p0_q <= '0;
      id_p0_q   <= '0;
      vld_p1_q  <= 1'b0;
      id_p1_q   <= '0;
      data_p1_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_p0_q  <= gnt_p0_d;
      vld_p0_q  <= vld_p0_d;
      addr_p0_q <= addr_p0_d;
      id_p0_q   <= id_p0_d;
      vld_p1_q  <= vld_p1_d;
      id_p1_q   <= id_p1_d;
      data_p1_q <= data_p1_d;
    end
  end

  assign gnt_o      = gnt_p0_q;
  assign rom_en_o   = vld_p0_q;
  assign rom_addr_o = addr_p0_q;
  assign rvalid_o   = vld_p1_q;
  assign rid_o      = id_p1_q;
  assign rdata_o    = data_p1_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: two instances (BURST_MAX=1 and 4) driven by shared
// stimulus, checked each cycle against a rotation/burst reference model and directed constants.
module tb_rom_access_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             en;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] addr;

  logic [NR-1:0] o_gnt   [2];
  logic          o_ren   [2];
  logic [AW-1:0] o_addr  [2];
  logic [DW-1:0] rom_d   [2];
  logic          o_rv    [2];
  logic [IW-1:0] o_rid   [2];
  logic [DW-1:0] o_rdata [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a ^ 8'hA5, a + 8'h3C, ~a, a};
  endfunction

  // ROM read of the registered address: data sits on rom_data_i while rom_en_o is high.
  assign rom_d[0] = rom_f(o_addr[0]);
  assign rom_d[1] = rom_f(o_addr[1]);

  rom_access_arbiter #(.NUM_REQ(NR), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(1)) u_b1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .addr_i(addr),
    .gnt_o(o_gnt[0]), .rom_en_o(o_ren[0]), .rom_addr_o(o_addr[0]), .rom_data_i(rom_d[0]),
    .rvalid_o(o_rv[0]), .rid_o(o_rid[0]), .rdata_o(o_rdata[0])
  );

  rom_access_arbiter #(.NUM_REQ(NR), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4)) u_b4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .addr_i(addr),
    .gnt_o(o_gnt[1]), .rom_en_o(o_ren[1]), .rom_addr_o(o_addr[1]), .rom_data_i(rom_d[1]),
    .rvalid_o(o_rv[1]), .rid_o(o_rid[1]), .rdata_o(o_rdata[1])
  );

  // Reference model state, index 0 -> BURST_MAX=1, index 1 -> BURST_MAX=4
  int            m_last  [2];
  int            m_run   [2];
  logic [NR-1:0] m_gnt   [2];
  logic [AW-1:0] m_addr  [2];
  int            m_id    [2];
  logic          m_rv    [2];
  int            m_rid   [2];
  logic [DW-1:0] m_rdata [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  bmax;
    int  w;
    bit  busy;
    int  order[$];
    for (int d = 0; d < 2; d++) begin
      bmax = (d == 0) ? 1 : 4;
      if (rst) begin
        m_last[d] = NR - 1; m_run[d] = 0; m_gnt[d] = '0; m_addr[d] = '0;
        m_id[d] = 0; m_rv[d] = 1'b0; m_rid[d] = 0; m_rdata[d] = '0;
      end else begin
        busy    = (m_gnt[d] != '0);
        m_rv[d] = busy;
        if (busy) begin
          m_rid[d]   = m_id[d];
          m_rdata[d] = rom_f(m_addr[d]);
        end
        if (!en || req == '0) begin
          m_gnt[d] = '0;
          m_run[d] = 0;
        end else begin
          if (busy && req[m_last[d]] && m_run[d] < bmax) begin
            w = m_last[d];
          end else begin
            order.delete();
            for (int i = 1; i <= NR; i++) order.push_back((m_last[d] + i) % NR);
            w = -1;
            foreach (order[n]) if (w < 0 && req[order[n]]) w = order[n];
          end
          if (busy && w == m_last[d]) m_run[d] = (m_run[d] + 1 > bmax) ? bmax : m_run[d] + 1;
          else m_run[d] = 1;
          m_gnt[d]  = NR'(1 << w);
          m_addr[d] = addr[w*AW +: AW];
          m_id[d]   = w;
          m_last[d] = w;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("gnt[%0d]", d), 64'(o_gnt[d]), 64'(m_gnt[d]));
      chk($sformatf("rom_en[%0d]", d), 64'(o_ren[d]), 64'(m_gnt[d] != '0));
      if (m_gnt[d] != '0 || rst) chk($sformatf("rom_addr[%0d]", d), 64'(o_addr[d]), 64'(m_addr[d]));
      chk($sformatf("rvalid[%0d]", d), 64'(o_rv[d]), 64'(m_rv[d]));
      if (m_rv[d] || rst) begin
        chk($sformatf("rid[%0d]", d), 64'(o_rid[d]), 64'(m_rid[d]));
        chk($sformatf("rdata[%0d]", d), 64'(o_rdata[d]), 64'(m_rdata[d]));
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_addr();
    addr = {$urandom, $urandom};
  endtask

  logic [NR-1:0] seq2 [5];

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; addr = '0;

    // 1: single request from requester 0
    do_reset();
    chk("rst_gnt", 64'(o_gnt[1]), 64'd0);
    chk("rst_rv", 64'(o_rv[1]), 64'd0);
    req = 4'b0001; addr = '0; addr[7:0] = 8'h10;
    tick();
    chk("t1_gnt", 64'(o_gnt[1]), 64'b0001);
    chk("t1_addr", 64'(o_addr[1]), 64'h10);
    req = '0;
    tick();
    chk("t1_rv", 64'(o_rv[1]), 64'd1);
    chk("t1_rid", 64'(o_rid[1]), 64'd0);
    chk("t1_rdata", 64'(o_rdata[1]), 64'(rom_f(8'h10)));

    // 2: all requesting, BURST_MAX=1 -> strict rotation
    do_reset();
    seq2[0] = 4'b0001; seq2[1] = 4'b0010; seq2[2] = 4'b0100; seq2[3] = 4'b1000; seq2[4] = 4'b0001;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_addr();
      tick();
      chk($sformatf("t2_gnt%0d", i), 64'(o_gnt[0]), 64'(seq2[i]));
      if (i > 0) chk($sformatf("t2_rv%0d", i), 64'(o_rv[0]), 64'd1);
    end

    // 3: requesters 0 and 2, BURST_MAX=4 -> bursts of four
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      rand_addr();
      tick();
      chk($sformatf("t3_gnt%0d", i), 64'(o_gnt[1]), (i >= 4 && i < 8) ? 64'b0100 : 64'b0001);
    end

    // 4: lone requester 3 keeps the ROM
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      rand_addr();
      tick();
      chk($sformatf("t4_gnt%0d", i), 64'(o_gnt[1]), 64'b1000);
    end

    // 5: enable dropped for three cycles mid-stream
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin rand_addr(); tick(); end
    en = 1'b0;
    tick();
    chk("t5_gnt_off", 64'(o_gnt[1]), 64'd0);
    chk("t5_pending_rv", 64'(o_rv[1]), 64'd1);
    chk("t5_pending_rid", 64'(o_rid[0]), 64'd2);
    tick();
    chk("t5_rv_drain", 64'(o_rv[1]), 64'd0);
    tick();
    en = 1'b1;
    tick();
    chk("t5_resume_b1", 64'(o_gnt[0]), 64'b1000);
    chk("t5_resume_b4", 64'(o_gnt[1]), 64'b0010);

    // 6: reset one cycle after a grant drops the read
    do_reset();
    req = 4'b1111;
    rand_addr();
    tick();
    chk("t6_gnt", 64'(o_gnt[1]), 64'b0001);
    rst = 1'b1;
    tick();
    chk("t6_rv_drop", 64'(o_rv[1]), 64'd0);
    chk("t6_gnt_rst", 64'(o_gnt[1]), 64'd0);
    chk("t6_rdata_rst", 64'(o_rdata[1]), 64'd0);
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk("t6_rv_none", 64'(o_rv[1]), 64'd0);
    chk("t6_first", 64'(o_gnt[1]), 64'b0001);

    // Randomized traffic with occasional enable drops and resets
    for (int i = 0; i < 400; i++) begin
      req = NR'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'b1111;
      rand_addr();
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
